// File: rtl/fir_buf_pkg.sv
// Shared types for the FIR tap-buffer controller: FSM state encoding and default ring depth.
package fir_buf_pkg;

    localparam int TAPS_DEFAULT = 11;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ
    } fir_state_e;

endpackage

// File: rtl/fir_tap_buf_ctrl.sv
// Ring-buffer controller for the FIR sample RAM: writes each sample, then streams the ring newest-to-oldest.
// Optional zero-fill of the ring on reset/clear is enabled by defining FIR_TAP_BUF_ZERO_INIT_EN.
module fir_tap_buf_ctrl
    import fir_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int BIT_WIDTH  = 32,
    parameter int TAPS       = TAPS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [BIT_WIDTH-1:0]  s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [BIT_WIDTH-1:0]  m_data,
    output logic                  m_last,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [BIT_WIDTH-1:0]  ram_wdi,
    input  logic [BIT_WIDTH-1:0]  ram_rdo
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(TAPS - 1);
    localparam logic [CNT_W-1:0]      TAPS_CNT = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(TAPS - 1);

`ifdef FIR_TAP_BUF_ZERO_INIT_EN
    localparam fir_state_e RESET_STATE = ST_INIT;
    localparam logic       CLEAR_EN    = 1'b1;
`else
    localparam fir_state_e RESET_STATE = ST_IDLE;
    localparam logic       CLEAR_EN    = 1'b0;
`endif

    fir_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  clear_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            head_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    // cnt_q doubles as the fill address in INIT and the issued-read count in READ.
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        s_ready   = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_waddr = '0;
        ram_raddr = '0;
        ram_wdi   = '0;
        clear_req = CLEAR_EN && clear;

        case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q[ADDR_WIDTH-1:0];
                head_d    = '0;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                s_ready = !clear_req;
                if (clear_req) begin
                    cnt_d   = '0;
                    state_d = ST_INIT;
                end else if (s_valid) begin
                    ram_we    = 1'b1;
                    ram_waddr = head_q;
                    ram_wdi   = s_data;
                    rptr_d    = head_q;
                    head_d    = (head_q == LAST_PTR) ? '0 : head_q + ADDR_WIDTH'(1);
                    cnt_d     = '0;
                    state_d   = ST_READ;
                end
            end

            ST_READ: begin
                ram_raddr = rptr_q;
                // A read is only issued into an empty or draining output slot, so a stall freezes ram_rdo.
                if (cnt_q != TAPS_CNT && (!m_valid_q || m_ready)) begin
                    ram_re    = 1'b1;
                    rptr_d    = (rptr_q == '0) ? LAST_PTR : rptr_q - ADDR_WIDTH'(1);
                    cnt_d     = cnt_q + CNT_W'(1);
                    m_valid_d = 1'b1;
                    m_last_d  = (cnt_q == LAST_CNT);
                end else if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase

        // Hold the RAM and input side quiet while reset is asserted.
        if (rst) begin
            s_ready   = 1'b0;
            ram_we    = 1'b0;
            ram_re    = 1'b0;
            ram_waddr = '0;
            ram_raddr = '0;
            ram_wdi   = '0;
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = ram_rdo;

endmodule

// File: tb/tb_fir_tap_buf_ctrl.sv
// Directed self-checking bench for fir_tap_buf_ctrl with a behavioural 1-cycle-latency RAM.
module tb_fir_tap_buf_ctrl;

  localparam int AW = 12;
  localparam int BW = 32;
  localparam int NT = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [BW-1:0] m_data;
  logic          m_last;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [BW-1:0] ram_wdi;
  logic [BW-1:0] ram_rdo;

  logic [BW-1:0] mem [0:15];
  logic [BW-1:0] ring [0:NT-1];
  logic [BW-1:0] got [0:15];
  int            head_m;
  int            n_assert = 0;
  int            n_fail = 0;

  fir_tap_buf_ctrl #(.ADDR_WIDTH(AW), .BIT_WIDTH(BW), .TAPS(NT)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .ram_we(ram_we), .ram_re(ram_re), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_wdi(ram_wdi), .ram_rdo(ram_rdo)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    ram_rdo = '0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr[3:0]] <= ram_wdi;
    if (ram_re) ram_rdo <= mem[ram_raddr[3:0]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_models();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < NT; i++) ring[i] = '0;
    head_m = 0;
  endtask

  task automatic check_init_fill();
    for (int i = 0; i < NT; i++) begin
      chk("init_we", 32'(ram_we), 32'd1);
      chk("init_waddr", 32'(ram_waddr), i);
      chk("init_wdi", ram_wdi, 32'd0);
      chk("init_s_ready", 32'(s_ready), 32'd0);
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_re", 32'(ram_re), 32'd0);
    chk("rst_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_raddr", 32'(ram_raddr), 32'd0);
    chk("rst_wdi", ram_wdi, 32'd0);
    zero_models();
    @(negedge clk);
    rst = 1'b0;
    #1;
`ifdef FIR_TAP_BUF_ZERO_INIT_EN
    check_init_fill();
`endif
    chk("ready_after_reset", 32'(s_ready), 32'd1);
    chk("idle_we", 32'(ram_we), 32'd0);
  endtask

  // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0 repeating
  task automatic run_frame(input logic [31:0] sample, input int mode);
    logic [31:0] exp_q[$];
    int          c;
    int          k;
    int          p;
    int          ra_exp;
    bit          done;
    bit          stall_prev;
    logic [31:0] data_prev;
    s_valid = 1'b1; s_data = sample;
    #1;
    chk("accept_s_ready", 32'(s_ready), 32'd1);
    chk("accept_we", 32'(ram_we), 32'd1);
    chk("accept_waddr", 32'(ram_waddr), head_m);
    chk("accept_wdi", ram_wdi, sample);
    ring[head_m] = sample;
    ra_exp = head_m;
    p = head_m;
    for (int i = 0; i < NT; i++) begin
      exp_q.push_back(ring[p]);
      p = (p == 0) ? NT - 1 : p - 1;
    end
    head_m = (head_m == NT - 1) ? 0 : head_m + 1;
    @(negedge clk);
    s_valid = 1'b0;
    c = 1; k = 0; done = 1'b0; stall_prev = 1'b0; data_prev = '0;
    while (!done && c < 100) begin
      m_ready = (mode == 0) ? 1'b1 : ((c - 1) % 3 == 0);
      #1;
      if (mode == 0 && c == 1) begin
        chk("first_re_cycle1", 32'(ram_re), 32'd1);
        chk("no_valid_cycle1", 32'(m_valid), 32'd0);
      end
      if (stall_prev) chk("stall_data_stable", m_data, data_prev);
      if (m_valid && !m_ready) chk("stall_no_re", 32'(ram_re), 32'd0);
      if (ram_re) begin
        chk("raddr", 32'(ram_raddr), ra_exp);
        ra_exp = (ra_exp == 0) ? NT - 1 : ra_exp - 1;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(m_valid), 32'd0);
        end else begin
          chk("m_data", m_data, exp_q.pop_front());
          got[k] = m_data;
          chk("m_last", 32'(m_last), 32'(k == NT - 1));
          k++;
        end
        if (m_last) begin
          done = 1'b1;
          if (mode == 0) chk("last_cycle", c, NT + 1);
        end
      end
      stall_prev = m_valid && !m_ready;
      data_prev = m_data;
      @(negedge clk);
      c++;
    end
    chk("frame_done", 32'(done), 32'd1);
    chk("word_count", k, NT);
    #1;
    chk("s_ready_after_frame", 32'(s_ready), 32'd1);
  endtask

  initial begin
    // reset and ring fill
    do_reset();

    // single sample, free-flowing output
    run_frame(32'h5, 0);
    chk("single_w0", got[0], 32'h5);
    chk("single_w1", got[1], 32'h0);
    chk("single_w10", got[10], 32'h0);

    // three frames back-to-back
    do_reset();
    run_frame(32'd1, 0);
    run_frame(32'd2, 0);
    run_frame(32'd3, 0);
    chk("b2b_w0", got[0], 32'd3);
    chk("b2b_w1", got[1], 32'd2);
    chk("b2b_w2", got[2], 32'd1);
    chk("b2b_w3", got[3], 32'd0);
    chk("b2b_w10", got[10], 32'd0);

    // wrap: twelfth sample lands at address 0
    do_reset();
    for (int s = 1; s <= 11; s++) run_frame(32'(s), 0);
    s_valid = 1'b1; s_data = 32'd12; #1;
    chk("wrap_waddr", 32'(ram_waddr), 32'd0);
    s_valid = 1'b0; #1;
    run_frame(32'd12, 0);
    chk("wrap_w0", got[0], 32'd12);
    chk("wrap_w1", got[1], 32'd11);
    chk("wrap_w10", got[10], 32'd2);

    // backpressure
    do_reset();
    run_frame(32'h7, 0);
    run_frame(32'h8, 1);
    chk("bp_w0", got[0], 32'h8);
    chk("bp_w1", got[1], 32'h7);
    chk("bp_w2", got[2], 32'h0);
    m_ready = 1'b1;

    // clear together with a sample in IDLE
    clear = 1'b1; s_valid = 1'b1; s_data = 32'h77;
`ifdef FIR_TAP_BUF_ZERO_INIT_EN
    #1;
    chk("clear_s_ready", 32'(s_ready), 32'd0);
    chk("clear_no_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    clear = 1'b0; s_valid = 1'b0;
    #1;
    check_init_fill();
    for (int i = 0; i < NT; i++) ring[i] = '0;
    head_m = 0;
    chk("clear_ready_after", 32'(s_ready), 32'd1);
    run_frame(32'h9, 0);
    chk("clear_w0", got[0], 32'h9);
    chk("clear_w1", got[1], 32'h0);
    chk("clear_w2", got[2], 32'h0);
`else
    run_frame(32'h77, 0);
    clear = 1'b0;
    chk("clear_ignored_w0", got[0], 32'h77);
    chk("clear_ignored_w1", got[1], 32'h8);
`endif

    // reset in the middle of a frame
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 32'h4;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1;
    chk("midframe_valid_before", 32'(m_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_m_last", 32'(m_last), 32'd0);
    chk("midrst_re", 32'(ram_re), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    do_reset();
    run_frame(32'h6, 0);
    chk("after_rst_w0", got[0], 32'h6);
    chk("after_rst_w1", got[1], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tap_buf_ctrl.md
# fir_tap_buf_ctrl

Circular-buffer controller that owns both ports of the FIR data RAM: it writes each incoming sample into an `TAPS`-entry ring and then replays the ring newest-to-oldest as a stream for the MAC. It sits between the AXI-Stream sample input and the tap-multiply datapath, driving the RAM's `we/re/waddr/raddr/wdi` and consuming `rdo`.

## Interface
- `ADDR_WIDTH`, 12, RAM address width.
- `BIT_WIDTH`, 32, sample width.
- `TAPS`, 11, ring depth and taps per frame, 2..2^ADDR_WIDTH.

- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `clear` in 1 — request re-zeroing of the ring.
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in BIT_WIDTH — sample input handshake.
- `m_valid` out 1 / `m_ready` in 1 / `m_data` out BIT_WIDTH / `m_last` out 1 — tap-sample output stream.
- `ram_we`, `ram_re` out 1 — RAM write/read enables.
- `ram_waddr`, `ram_raddr` out ADDR_WIDTH — RAM addresses; values 0..TAPS-1, zero-extended.
- `ram_wdi` out BIT_WIDTH — RAM write data.
- `ram_rdo` in BIT_WIDTH — RAM read data; registered, 1-cycle latency, holds while `ram_re`=0.

## Operation
- FSM: INIT, IDLE, READ.
- INIT: one write per cycle, `ram_wdi`=0, addresses 0..TAPS-1 ascending; `head`←0; then IDLE.
- IDLE: `s_ready = !clear`. On `s_valid && s_ready`: `ram_we`=1, `ram_waddr`=`head`, `ram_wdi`=`s_data` in the same cycle; latch `rptr`←`head`; `head`←(`head`+1) mod TAPS; go to READ.
- IDLE with `clear`=1: go to INIT; any sample that cycle is not accepted.
- READ: issue TAPS reads at `rptr`, `rptr`-1, …, wrapping 0→TAPS-1. A read is issued when `!m_valid || m_ready`. `m_valid` is set the cycle after an issue. `m_data` = `ram_rdo`, passed through with no register. `m_last`=1 with the TAPS-th word. After the handshake on `m_last`, go to IDLE.
- `clear` is ignored outside IDLE. `s_ready`=0 in INIT and READ.
- Pointer arithmetic is modulo TAPS via compare-and-wrap; no power-of-two assumption.

## Timing
- Reset values: `s_ready`=0, `m_valid`=0, `m_last`=0, `ram_we`=0, `ram_re`=0, `ram_waddr`=0, `ram_raddr`=0, `ram_wdi`=0, `head`=0. State after reset is INIT.
- Sample accepted at cycle 0 → first `ram_re` at cycle 1 → first `m_valid` at cycle 2.
- With `m_ready` held at 1: one word per cycle; `m_last` at cycle TAPS+1; `s_ready` high again at cycle TAPS+2.
- Stall (`m_valid && !m_ready`): no `ram_re`, so `m_data` stays stable.
- The write at cycle 0 is visible to the read issued at cycle 1.
- `rst` mid-frame: all outputs take reset values the next cycle; the partial frame is discarded; INIT restarts.

## Configuration
- `FIR_TAP_BUF_ZERO_INIT_EN` defined: INIT state present. Reset and `clear` both zero-fill the ring, taking TAPS cycles.
- Not defined: reset enters IDLE directly with `s_ready`=1 one cycle after `rst` falls. `clear` is ignored. Ring contents are undefined until TAPS samples have been written.

## Structure
- Package `fir_buf_pkg`: FSM state enum (INIT, IDLE, READ) and the `TAPS_DEFAULT`=11 constant.
- No sub-module. The RAM is instantiated by the parent; this block contains only the FSM and the `head`/`rptr`/read-count counters.

## Test plan
- Reset, macro on: exactly 11 cycles of `ram_we`=1 with `ram_waddr` 0..10 and `ram_wdi`=0, `s_ready`=0 throughout; `s_ready`=1 on the next cycle.
- Single sample 0x5, `m_ready`=1: write at address 0; reads at 0,10,9..1; `m_data` = 5 followed by ten 0s; `m_last` only on the 11th word.
- Samples 1,2,3 back-to-back: third frame outputs 3,2,1 then eight 0s.
- Wrap: samples 1..12: the 12th is written at address 0; its frame outputs 12,11,…,2.
- Backpressure: `m_ready` pattern 1,0,0,1,… → no `ram_re` while stalled, `m_data` constant while stalled, 11 words delivered in order.
- `clear` together with `s_valid` in IDLE: sample not accepted, INIT re-zeros the ring. `rst` asserted mid-READ: `m_valid`=0 the next cycle and INIT restarts.
